// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman game datapath: state encoding,
// ASCII constants and default geometry.
package hangman_pkg;

    localparam int WORD_LEN_DEFAULT   = 7;
    localparam int CHAR_W_DEFAULT     = 7;
    localparam int LIVES_INIT_DEFAULT = 7;

    localparam logic [6:0] ASCII_A     = 7'h41;
    localparam logic [6:0] ASCII_Z     = 7'h5A;
    localparam logic [6:0] ASCII_SPACE = 7'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_CHECK,
        ST_WIN,
        ST_LOSE
    } state_t;

endpackage

// File: rtl/guess_tracker_if.sv
// Game-state bus between the letter selector / word generator and the
// tracker, plus the tracker's results toward renderer and 7-seg.
interface guess_tracker_if
    import hangman_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEFAULT,
    parameter int CHAR_W   = CHAR_W_DEFAULT
);
    logic                         restart;
    logic [WORD_LEN*CHAR_W-1:0]   word_flat;
    logic                         guess_strobe;
    logic [CHAR_W-1:0]            guess_ascii;

    logic [WORD_LEN-1:0]          reveal_mask;
    logic [25:0]                  used_letters;
    logic [2:0]                   lives;
    logic                         game_over;
    logic                         win;
    logic                         busy;
    logic                         hit_p;
    logic                         miss_p;
    logic                         dup_p;
    logic                         bad_p;

    modport master (
        output restart, word_flat, guess_strobe, guess_ascii,
        input  reveal_mask, used_letters, lives, game_over, win, busy,
               hit_p, miss_p, dup_p, bad_p
    );

    modport slave (
        input  restart, word_flat, guess_strobe, guess_ascii,
        output reveal_mask, used_letters, lives, game_over, win, busy,
               hit_p, miss_p, dup_p, bad_p
    );

endinterface

// File: rtl/hangman_match_vec.sv
// Per-slot equality of a packed word against a single character.
module hangman_match_vec #(
    parameter int WORD_LEN = 7,
    parameter int CHAR_W   = 7
) (
    input  logic [WORD_LEN*CHAR_W-1:0] word,
    input  logic [CHAR_W-1:0]          ch,
    output logic [WORD_LEN-1:0]        match
);

    always_comb begin
        match = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            match[i] = (word[i*CHAR_W +: CHAR_W] == ch);
        end
    end

endmodule

// File: rtl/guess_tracker.sv
// Hangman game-state engine: latches the target word on restart, scores
// guesses against every slot and tracks reveal mask, used letters and lives.
module guess_tracker
    import hangman_pkg::*;
#(
    parameter int WORD_LEN   = WORD_LEN_DEFAULT,
    parameter int CHAR_W     = CHAR_W_DEFAULT,
    parameter int LIVES_INIT = LIVES_INIT_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    guess_tracker_if.slave bus
);

    localparam logic [2:0] LIVES_RST = 3'(LIVES_INIT);

    state_t                      state, state_n;
    logic [WORD_LEN*CHAR_W-1:0]  word_q, word_n;
    logic [CHAR_W-1:0]           guess_q, guess_n;
    logic [WORD_LEN-1:0]         mask_q, mask_n;
    logic [25:0]                 used_q, used_n;
    logic [2:0]                  lives_q, lives_n;
    logic                        hit_q, hit_n;
    logic                        miss_q, miss_n;
    logic                        dup_q, dup_n;
    logic                        bad_q, bad_n;

    logic [WORD_LEN-1:0]         match_guess;
    logic [WORD_LEN-1:0]         match_space;
    logic [4:0]                  guess_idx;
    logic                        strobe_is_letter;

    hangman_match_vec #(.WORD_LEN(WORD_LEN), .CHAR_W(CHAR_W)) u_match_guess (
        .word  (word_q),
        .ch    (guess_q),
        .match (match_guess)
    );

    hangman_match_vec #(.WORD_LEN(WORD_LEN), .CHAR_W(CHAR_W)) u_match_space (
        .word  (word_q),
        .ch    (CHAR_W'(ASCII_SPACE)),
        .match (match_space)
    );

    assign guess_idx        = 5'(guess_q - CHAR_W'(ASCII_A));
    assign strobe_is_letter = (bus.guess_ascii >= CHAR_W'(ASCII_A)) &&
                              (bus.guess_ascii <= CHAR_W'(ASCII_Z));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            word_q  <= '0;
            guess_q <= '0;
            mask_q  <= '0;
            used_q  <= '0;
            lives_q <= LIVES_RST;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            dup_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state   <= state_n;
            word_q  <= word_n;
            guess_q <= guess_n;
            mask_q  <= mask_n;
            used_q  <= used_n;
            lives_q <= lives_n;
            hit_q   <= hit_n;
            miss_q  <= miss_n;
            dup_q   <= dup_n;
            bad_q   <= bad_n;
        end
    end

    // Restart overrides everything, including a guess being scored in CHECK.
    // The word is captured on the restart edge so LOAD can decode spaces from it.
    always_comb begin
        state_n = state;
        word_n  = word_q;
        guess_n = guess_q;
        mask_n  = mask_q;
        used_n  = used_q;
        lives_n = lives_q;
        hit_n   = 1'b0;
        miss_n  = 1'b0;
        dup_n   = 1'b0;
        bad_n   = 1'b0;

        if (bus.restart) begin
            state_n = ST_LOAD;
            word_n  = bus.word_flat;
        end else begin
            case (state)
                ST_LOAD: begin
                    mask_n  = match_space;
                    used_n  = '0;
                    lives_n = LIVES_RST;
                    state_n = (&match_space) ? ST_WIN : ST_PLAY;
                end
                ST_PLAY: begin
                    if (bus.guess_strobe) begin
                        if (strobe_is_letter) begin
                            guess_n = bus.guess_ascii;
                            state_n = ST_CHECK;
                        end else begin
                            bad_n = 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (used_q[guess_idx]) begin
                        dup_n = 1'b1;
                    end else begin
                        used_n[guess_idx] = 1'b1;
                        if (|match_guess) begin
                            mask_n = mask_q | match_guess;
                            hit_n  = 1'b1;
                        end else begin
                            lives_n = lives_q - 3'd1;
                            miss_n  = 1'b1;
                        end
                    end
                    if (&mask_n) begin
                        state_n = ST_WIN;
                    end else if (lives_n == 3'd0) begin
                        state_n = ST_LOSE;
                    end else begin
                        state_n = ST_PLAY;
                    end
                end
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    state_n = state;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.reveal_mask  = mask_q;
    assign bus.used_letters = used_q;
    assign bus.lives        = lives_q;
    assign bus.game_over    = (state == ST_WIN) || (state == ST_LOSE);
    assign bus.win          = (state == ST_WIN);
    assign bus.busy         = (state == ST_LOAD) || (state == ST_CHECK);
    assign bus.hit_p        = hit_q;
    assign bus.miss_p       = miss_q;
    assign bus.dup_p        = dup_q;
    assign bus.bad_p        = bad_q;

endmodule
